// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, issue FSM states and op classifiers.
// Used by the E-stage issue controller and by the instruction decoder.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd3;
    localparam logic [3:0] OP_MTLO  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op != OP_NONE) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_read_op(input logic [3:0] op);
        return op inside {OP_MFHI, OP_MFLO};
    endfunction

endpackage

// File: rtl/mdu_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async, active-low), clr_i, inc_i, cnt_o[W-1:0].
module mdu_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage initiator for the Start/Busy multiply-divide unit: issues one start
// per E instruction, stalls F/D/E while the unit is busy, latches mfhi/mflo
// data for M, counts stall cycles and flags a hung unit.
// Ports: clk, reset (async, active-low)
//   E stage : e_valid, e_op[3:0], e_rs/e_rt[DW], e_hold, flush
//   MDU     : mdu_start, mdu_op[3:0], mdu_d1/mdu_d2[DW] out; mdu_busy, mdu_out[DW] in
//   Pipeline: mdu_stall, m_mdu_data[DW], stall_cnt[CNT_W], wdog_err
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int DW       = 32,
    parameter int CNT_W    = 32,
    parameter int WDOG_MAX = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_op,
    input  logic [DW-1:0]    e_rs,
    input  logic [DW-1:0]    e_rt,
    input  logic             e_hold,
    input  logic             flush,
    output logic             mdu_start,
    output logic [3:0]       mdu_op,
    output logic [DW-1:0]    mdu_d1,
    output logic [DW-1:0]    mdu_d2,
    input  logic             mdu_busy,
    input  logic [DW-1:0]    mdu_out,
    output logic             mdu_stall,
    output logic [DW-1:0]    m_mdu_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wdog_err
);

    localparam int BR_W = $clog2(WDOG_MAX + 1);

    mdu_state_e    state_q;
    mdu_state_e    state_d;
    logic          issued_q;
    logic          issued_d;
    logic [DW-1:0] m_data_q;
    logic [DW-1:0] m_data_d;
    logic          wdog_q;
    logic          wdog_d;

    logic [BR_W-1:0] busy_run;
    logic            is_mdu;
    logic            long_op;
    logic            unit_free;
    logic            advance;

    assign is_mdu  = e_valid & is_mdu_op(e_op);
    assign long_op = is_long_op(e_op);

    // The last WAIT cycle (busy already low) counts as free: the stall has
    // dropped there, so refusing to issue would let the op leave E unissued.
    assign unit_free = !mdu_busy && (state_q != ARM);

    // Gated by reset so nothing issues or stalls while the block is held.
    assign mdu_start = reset & is_mdu & !issued_q & !flush & unit_free;
    assign mdu_stall = reset & is_mdu & !flush
                     & (mdu_busy | (state_q == ARM));

    assign mdu_op = mdu_start ? e_op : OP_NONE;
    assign mdu_d1 = e_rs;
    assign mdu_d2 = e_rt;

    assign advance = !e_hold && !mdu_stall;

    // ARM bridges the cycle between a long start and busy being seen high;
    // if busy never rises (divide by zero) it falls straight back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mdu_start && long_op) state_d = ARM;
            end
            ARM: begin
                state_d = mdu_busy ? WAIT : IDLE;
            end
            WAIT: begin
                if (!mdu_busy) begin
                    state_d = (mdu_start && long_op) ? ARM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One start per E instruction, even when E is held for many cycles.
    always_comb begin
        issued_d = issued_q;
        if (flush || advance) begin
            issued_d = 1'b0;
        end else if (mdu_start) begin
            issued_d = 1'b1;
        end
    end

    always_comb begin
        m_data_d = m_data_q;
        if (mdu_start && is_read_op(e_op)) begin
            m_data_d = mdu_out;
        end
    end

    always_comb begin
        wdog_d = wdog_q;
        if (mdu_busy && (busy_run == BR_W'(WDOG_MAX - 1))) begin
            wdog_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            issued_q <= 1'b0;
            m_data_q <= '0;
            wdog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            m_data_q <= m_data_d;
            wdog_q   <= wdog_d;
        end
    end

    mdu_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (1'b0),
        .inc_i (mdu_stall),
        .cnt_o (stall_cnt)
    );

    mdu_sat_counter #(
        .W (BR_W)
    ) u_busy_run (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (!mdu_busy),
        .inc_i (mdu_busy),
        .cnt_o (busy_run)
    );

    assign m_mdu_data = m_data_q;
    assign wdog_err   = wdog_q;

endmodule
